// File: rtl/mux_demux_pkg.sv
// Shared encodings for the 2:1 merge mux and its 1:2 demux counterpart.
package mux_demux_pkg;

    localparam logic SEL_I0       = 1'b0;
    localparam logic SEL_I1       = 1'b1;
    // Reset as if i1 won last, so i0 takes the first conflict.
    localparam logic LAST_SEL_RST = SEL_I1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/mux2_1_stream_rr_arb2.sv
// Two-request round-robin arbiter; remembers the last granted index.
module rr_arb2
    import mux_demux_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_idx,
    output logic       last_sel
);

    always_comb begin
        gnt     = 2'b00;
        gnt_idx = SEL_I0;
        if (en) begin
            unique case (req)
                2'b01: begin
                    gnt     = 2'b01;
                    gnt_idx = SEL_I0;
                end
                2'b10: begin
                    gnt     = 2'b10;
                    gnt_idx = SEL_I1;
                end
                2'b11: begin
                    // Contention: the side that did not win last time goes now.
                    gnt_idx = ~last_sel;
                    gnt     = (last_sel == SEL_I1) ? 2'b01 : 2'b10;
                end
                default: begin
                    gnt     = 2'b00;
                    gnt_idx = SEL_I0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_sel <= LAST_SEL_RST;
        end else if (en && (|gnt)) begin
            last_sel <= gnt_idx;
        end
    end

endmodule

// File: rtl/mux2_1_stream.sv
// 2:1 merging stream mux with a single registered output slot and round-robin arbitration.
//
// Handshake: a word moves on any port exactly when valid & ready are both high at a
// rising clk edge. valid never waits on ready; ready here is combinational from the
// inputs' valid and o_ready, and is only raised toward a valid input.
module mux2_1_stream
    import mux_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0_d,
    input  logic             i0_valid,
    output logic             i0_ready,
    input  logic [WIDTH-1:0] i1_d,
    input  logic             i1_valid,
    output logic             i1_ready,
    output logic [WIDTH-1:0] o_d,
    output logic             o_s0,
    output logic             o_valid,
    input  logic             o_ready
);

    slot_state_t state;
    slot_state_t state_next;
    logic        slot_free;
    logic        arb_en;
    logic [1:0]  gnt;
    logic        gnt_idx;
    logic        last_sel;
    logic        in_xfer;
    logic        out_xfer;

    assign o_valid   = (state == SLOT_FULL);
    assign slot_free = (state == SLOT_EMPTY) | o_ready;
    // Nothing is accepted while reset is asserted.
    assign arb_en    = slot_free & ~rst;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      ({i1_valid, i0_valid}),
        .en       (arb_en),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .last_sel (last_sel)
    );

    assign i0_ready = gnt[0];
    assign i1_ready = gnt[1];
    assign in_xfer  = |gnt;
    assign out_xfer = o_valid & o_ready;

    always_comb begin
        state_next = state;
        if (in_xfer) begin
            state_next = SLOT_FULL;
        end else if (out_xfer) begin
            state_next = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_d  <= '0;
            o_s0 <= SEL_I0;
        end else if (in_xfer) begin
            o_d  <= (gnt_idx == SEL_I1) ? i1_d : i0_d;
            o_s0 <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_mux2_1_stream.sv
// Randomized and directed bench for mux2_1_stream against a queue-based reference model.
module tb_mux2_1_stream;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] i0_d;
    logic             i0_valid;
    logic             i0_ready;
    logic [WIDTH-1:0] i1_d;
    logic             i1_valid;
    logic             i1_ready;
    logic [WIDTH-1:0] o_d;
    logic             o_s0;
    logic             o_valid;
    logic             o_ready;

    int checks;
    int fails;

    // Scoreboard: words accepted but not yet consumed, as {source, data}.
    logic [WIDTH:0] exp_q[$];
    logic           m_last;
    logic           e_r0;
    logic           e_r1;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux2_1_stream #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .i0_d     (i0_d),
        .i0_valid (i0_valid),
        .i0_ready (i0_ready),
        .i1_d     (i1_d),
        .i1_valid (i1_valid),
        .i1_ready (i1_ready),
        .o_d      (o_d),
        .o_s0     (o_s0),
        .o_valid  (o_valid),
        .o_ready  (o_ready)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_ready();
        logic free;
        free = (exp_q.size() == 0) || o_ready;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!rst && free) begin
            if (i0_valid && i1_valid) begin
                if (m_last) e_r0 = 1'b1;
                else        e_r1 = 1'b1;
            end else begin
                e_r0 = i0_valid;
                e_r1 = i1_valid;
            end
        end
    endtask

    // One cycle: inputs already driven by caller, away from the edge.
    task automatic step();
        logic [WIDTH:0] w;
        #1;
        model_ready();
        check_eq("i0_ready", {31'b0, i0_ready}, {31'b0, e_r0});
        check_eq("i1_ready", {31'b0, i1_ready}, {31'b0, e_r1});
        if (!rst && o_valid && o_ready && exp_q.size() != 0) begin
            w = exp_q[0];
            check_eq("consumed_word", {23'b0, o_s0, o_d}, {23'b0, w});
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_last = 1'b1;
        end else begin
            if (o_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (e_r0) begin exp_q.push_back({1'b0, i0_d}); m_last = 1'b0; end
            if (e_r1) begin exp_q.push_back({1'b1, i1_d}); m_last = 1'b1; end
        end
        #1;
        check_eq("o_valid", {31'b0, o_valid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            w = exp_q[0];
            check_eq("o_word", {23'b0, o_s0, o_d}, {23'b0, w});
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v0, input logic [WIDTH-1:0] d0,
                         input logic v1, input logic [WIDTH-1:0] d1, input logic ordy);
        i0_valid = v0;
        i0_d     = d0;
        i1_valid = v1;
        i1_d     = d1;
        o_ready  = ordy;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        m_last = 1'b1;

        // Reset with both inputs competing.
        rst = 1'b1;
        drive(1'b1, 8'hAA, 1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("rst_o_d", {24'b0, o_d}, 32'h0);
            check_eq("rst_o_s0", {31'b0, o_s0}, 32'h0);
        end
        rst = 1'b0;
        #1;
        check_eq("post_rst_i0_ready", {31'b0, i0_ready}, 32'h1);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();
        step();

        // Single source on i1.
        drive(1'b0, 8'h00, 1'b1, 8'h3C, 1'b1);
        #1;
        check_eq("single_i1_ready", {31'b0, i1_ready}, 32'h1);
        check_eq("single_i0_ready", {31'b0, i0_ready}, 32'h0);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check_eq("single_o_d", {24'b0, o_d}, 32'h3C);
        check_eq("single_o_s0", {31'b0, o_s0}, 32'h1);
        step();

        // Contention: strict alternation starting with i0 (last winner was i1).
        drive(1'b1, 8'h01, 1'b1, 8'h81, 1'b1);
        step();
        check_eq("cont_w0", {23'b0, o_s0, o_d}, {23'b0, 1'b0, 8'h01});
        drive(1'b1, 8'h02, 1'b1, 8'h81, 1'b1);
        step();
        check_eq("cont_w1", {23'b0, o_s0, o_d}, {23'b0, 1'b1, 8'h81});
        drive(1'b1, 8'h02, 1'b1, 8'h82, 1'b1);
        step();
        check_eq("cont_w2", {23'b0, o_s0, o_d}, {23'b0, 1'b0, 8'h02});
        drive(1'b1, 8'h03, 1'b1, 8'h82, 1'b1);
        step();
        check_eq("cont_w3", {23'b0, o_s0, o_d}, {23'b0, 1'b1, 8'h82});
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        step();

        // Backpressure: fill with 0x11 from i0, then stall 3 cycles.
        drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
        step();
        drive(1'b1, 8'h12, 1'b1, 8'h92, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_hold_d", {24'b0, o_d}, 32'h11);
        end
        o_ready = 1'b1;
        #1;
        check_eq("bp_release_i1_ready", {31'b0, i1_ready}, 32'h1);
        check_eq("bp_release_i0_ready", {31'b0, i0_ready}, 32'h0);
        step();
        check_eq("bp_next_word", {23'b0, o_valid, o_d}, {23'b0, 1'b1, 8'h92});

        // Reset mid-stream while 0x77 is held under backpressure.
        drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step();
        check_eq("mid_held_77", {24'b0, o_d}, 32'h77);
        rst = 1'b1;
        drive(1'b1, 8'h44, 1'b1, 8'hC4, 1'b0);
        step();
        check_eq("mid_rst_o_valid", {31'b0, o_valid}, 32'h0);
        rst = 1'b0;
        drive(1'b1, 8'h45, 1'b1, 8'hC5, 1'b1);
        #1;
        check_eq("mid_rst_grant_i0", {31'b0, i0_ready}, 32'h1);
        step();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 99) < 2);
            i0_valid = $urandom_range(0, 99) < 60;
            i1_valid = $urandom_range(0, 99) < 60;
            i0_d     = WIDTH'($urandom);
            i1_d     = WIDTH'($urandom);
            o_ready  = $urandom_range(0, 99) < 70;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
